// File: rtl/wb_regfile_if.sv
// MEM/WB commit bus and ID-side read ports of the write-back register file.
// master drives writes and read requests; slave is the register file.
interface wb_regfile_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] w_reg_addr_in;
  logic [DATA_W-1:0] w_reg_data_in;
  logic              w_reg_en_in;
  logic [DATA_W-1:0] hi_regs_in;
  logic [DATA_W-1:0] lo_regs_in;
  logic              hilo_wen_in;
  logic              rd1_en;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic              rd2_en;
  logic [ADDR_W-1:0] rd2_addr;
  logic [DATA_W-1:0] rd2_data;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output w_reg_addr_in,
    output w_reg_data_in,
    output w_reg_en_in,
    output hi_regs_in,
    output lo_regs_in,
    output hilo_wen_in,
    output rd1_en,
    output rd1_addr,
    output rd2_en,
    output rd2_addr,
    input  rd1_data,
    input  rd2_data,
    input  hi_out,
    input  lo_out
  );

  modport slave (
    input  w_reg_addr_in,
    input  w_reg_data_in,
    input  w_reg_en_in,
    input  hi_regs_in,
    input  lo_regs_in,
    input  hilo_wen_in,
    input  rd1_en,
    input  rd1_addr,
    input  rd2_en,
    input  rd2_addr,
    output rd1_data,
    output rd2_data,
    output hi_out,
    output lo_out
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: GPR file plus HI/LO with same-cycle write-to-read bypass.
// Reads are combinational; r0 is hardwired to zero.
module wb_regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  wb_regfile_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              gpr_we;

  assign gpr_we = bus.w_reg_en_in &&
                  (bus.w_reg_addr_in != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (gpr_we)
        regs[bus.w_reg_addr_in] <= bus.w_reg_data_in;
      if (bus.hilo_wen_in) begin
        hi_q <= bus.hi_regs_in;
        lo_q <= bus.lo_regs_in;
      end
    end
  end

  // Mutually exclusive selects so the decoder is a true one-hot case.
  logic r1_zero, r1_byp, r1_mem;
  logic r2_zero, r2_byp, r2_mem;

  always_comb begin
    r1_zero = !rst_n || !bus.rd1_en ||
              (bus.rd1_addr == '0);
    r1_byp  = !r1_zero && bus.w_reg_en_in &&
              (bus.w_reg_addr_in == bus.rd1_addr);
    r1_mem  = !r1_zero && !r1_byp;
    r2_zero = !rst_n || !bus.rd2_en ||
              (bus.rd2_addr == '0);
    r2_byp  = !r2_zero && bus.w_reg_en_in &&
              (bus.w_reg_addr_in == bus.rd2_addr);
    r2_mem  = !r2_zero && !r2_byp;
  end

  always_comb begin
    bus.rd1_data = '0;
    unique case (1'b1)
      r1_zero: bus.rd1_data = '0;
      r1_byp:  bus.rd1_data = bus.w_reg_data_in;
      r1_mem:  bus.rd1_data = regs[bus.rd1_addr];
      default: bus.rd1_data = '0;
    endcase
  end

  always_comb begin
    bus.rd2_data = '0;
    unique case (1'b1)
      r2_zero: bus.rd2_data = '0;
      r2_byp:  bus.rd2_data = bus.w_reg_data_in;
      r2_mem:  bus.rd2_data = regs[bus.rd2_addr];
      default: bus.rd2_data = '0;
    endcase
  end

  always_comb begin
    bus.hi_out = '0;
    bus.lo_out = '0;
    if (rst_n) begin
      bus.hi_out = bus.hilo_wen_in ? bus.hi_regs_in : hi_q;
      bus.lo_out = bus.hilo_wen_in ? bus.lo_regs_in : lo_q;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios then random traffic
// checked against an array-based architectural model.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  wb_regfile #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem[32];
  logic [31:0] m_hi, m_lo;
  int          checks = 0;
  int          errors = 0;
  bit          done = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic en,
                                         input logic [4:0] a);
    if (!rst_n || !en || a == 5'd0) return 32'h0;
    if (bus.w_reg_en_in && bus.w_reg_addr_in == a)
      return bus.w_reg_data_in;
    return mem[a];
  endfunction

  task automatic cyc(input logic rst, input logic wen,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic hwen, input logic [31:0] hv,
                     input logic [31:0] lv,
                     input logic e1, input logic [4:0] a1,
                     input logic e2, input logic [4:0] a2);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    bus.w_reg_en_in = wen;
    bus.w_reg_addr_in = wa;
    bus.w_reg_data_in = wd;
    bus.hilo_wen_in = hwen;
    bus.hi_regs_in = hv;
    bus.lo_regs_in = lv;
    bus.rd1_en = e1;
    bus.rd1_addr = a1;
    bus.rd2_en = e2;
    bus.rd2_addr = a2;
    #1;
    e.rd1 = exp_rd(e1, a1);
    e.rd2 = exp_rd(e2, a2);
    e.hi = !rst ? 32'h0 : (hwen ? hv : m_hi);
    e.lo = !rst ? 32'h0 : (hwen ? lv : m_lo);
    sb_q.push_back(e);
    // State the architecture holds after the coming edge.
    if (!rst) begin
      foreach (mem[i]) mem[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else begin
      if (wen && wa != 5'd0) mem[wa] = wd;
      if (hwen) begin
        m_hi = hv;
        m_lo = lv;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rd1_data", bus.rd1_data, e.rd1);
        chk("rd2_data", bus.rd2_data, e.rd2);
        chk("hi_out", bus.hi_out, e.hi);
        chk("lo_out", bus.lo_out, e.lo);
      end
    end
  end

  initial begin : stim
    foreach (mem[i]) mem[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    bus.w_reg_en_in = 0;
    bus.w_reg_addr_in = 0;
    bus.w_reg_data_in = 0;
    bus.hilo_wen_in = 0;
    bus.hi_regs_in = 0;
    bus.lo_regs_in = 0;
    bus.rd1_en = 0;
    bus.rd1_addr = 0;
    bus.rd2_en = 0;
    bus.rd2_addr = 0;
    // reset with a write pending
    repeat (2)
      cyc(0, 1, 5, 32'hDEADBEEF, 1, 32'h5, 32'h6, 1, 5, 1, 5);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    // write then readback, and disabled port
    cyc(1, 1, 7, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 7);
    // bypass on both ports
    cyc(1, 1, 3, 32'hA5A5A5A5, 0, 0, 0, 1, 3, 1, 3);
    cyc(1, 0, 3, 32'h0, 0, 0, 0, 1, 3, 1, 3);
    // r0 is never written or bypassed
    cyc(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    // HI/LO
    cyc(1, 0, 0, 0, 1, 32'h1, 32'hFFFFFFFE, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 32'h77, 32'h88, 0, 0, 0, 0);
    // reset discards a concurrent write
    cyc(1, 1, 9, 32'h11, 0, 0, 0, 1, 9, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    cyc(0, 1, 9, 32'h22, 1, 32'h3, 32'h4, 1, 9, 1, 9);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9);
    cyc(1, 1, 9, 32'h33, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9);
    // random traffic
    for (int n = 0; n < 3000; n++)
      cyc(($urandom_range(0, 60) != 0),
          $urandom_range(0, 1), 5'($urandom_range(0, 31)),
          $urandom, ($urandom_range(0, 3) == 0), $urandom, $urandom,
          ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 31)),
          ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 31)));
    repeat (3) @(posedge clk);
    done = 1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MIPS pipeline: consumes the registered MEM/WB outputs (GPR write address/data/enable, HI/LO data/enable) and commits them to architectural state.
- Holds the 32-entry general-purpose register file and the HI/LO register pair.
- Provides two combinational GPR read ports and HI/LO read outputs to the decode/execute stages.
- Includes same-cycle write-to-read bypass, so a writer in WB and a reader in ID need no extra forwarding path.

Parameters:
- ADDR_W, 5, GPR address width; number of registers is 2**ADDR_W.
- DATA_W, 32, GPR and HI/LO data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- w_reg_addr_in  in  ADDR_W  GPR write address from MEM/WB.
- w_reg_data_in  in  DATA_W  GPR write data from MEM/WB.
- w_reg_en_in  in  1  GPR write enable from MEM/WB.
- hi_regs_in  in  DATA_W  HI write data from MEM/WB.
- lo_regs_in  in  DATA_W  LO write data from MEM/WB.
- hilo_wen_in  in  1  HI/LO write enable; writes both HI and LO.
- rd1_en  in  1  read port 1 enable.
- rd1_addr  in  ADDR_W  read port 1 address.
- rd1_data  out  DATA_W  read port 1 data, combinational.
- rd2_en  in  1  read port 2 enable.
- rd2_addr  in  ADDR_W  read port 2 address.
- rd2_data  out  DATA_W  read port 2 data, combinational.
- hi_out  out  DATA_W  current HI value, bypassed, combinational.
- lo_out  out  DATA_W  current LO value, bypassed, combinational.

Behaviour:
- Reset (rst_n=0 at a rising edge): all GPRs, HI and LO cleared to 0; write inputs ignored on that edge.
- While rst_n=0, rd1_data, rd2_data, hi_out and lo_out are forced to 0 combinationally.
- GPR write:
  - Occurs on a rising edge when rst_n=1, w_reg_en_in=1 and w_reg_addr_in != 0.
  - Register 0 is never written and always reads 0.
  - Write latency: the value is architecturally visible from the next cycle.
- HI/LO write:
  - Occurs on a rising edge when rst_n=1 and hilo_wen_in=1.
  - HI <= hi_regs_in and LO <= lo_regs_in in the same edge; there are no partial writes.
- Read port n, priority order:
  1. rst_n=0 -> 0.
  2. rdn_en=0 -> 0.
  3. rdn_addr=0 -> 0.
  4. w_reg_en_in=1 and w_reg_addr_in==rdn_addr -> w_reg_data_in (bypass).
  5. Otherwise -> stored register value.
- Both read ports are independent; same address on both ports returns identical data, including bypass.
- hi_out = hilo_wen_in ? hi_regs_in : HI. lo_out = hilo_wen_in ? lo_regs_in : LO. Both are 0 under reset.
- No clock gating and no read-side state; reads never modify storage.
- Reset asserted mid-stream discards any write presented on that edge; the first write after deassertion is honoured normally.
- Write-enable inputs carrying X/unused addresses when enable=0 must have no effect.

Test Plan:
- Reset then reads: hold rst_n=0 for 2 cycles with w_reg_en_in=1, addr=5, data=0xDEADBEEF -> after release, rd1_addr=5, rd1_en=1 reads 0x00000000; hi_out=lo_out=0.
- Write/readback: write addr=7, data=0x12345678 at cycle N; cycle N+1 rd2_addr=7 -> 0x12345678; rd2_en=0 -> 0.
- Bypass: same cycle w_reg_en_in=1, addr=3, data=0xA5A5A5A5 with rd1_addr=rd2_addr=3 -> both read 0xA5A5A5A5 combinationally; stored value visible next cycle with w_reg_en_in=0.
- Zero register: write addr=0, data=0xFFFFFFFF -> rd1_addr=0 reads 0 in the same cycle (no bypass) and in the next cycle.
- HI/LO: hilo_wen_in=1, hi=0x00000001, lo=0xFFFFFFFE -> hi_out/lo_out show the new values in the same cycle; after hilo_wen_in=0 they hold those values; a second write with hilo_wen_in=0 presents new data but does not change the outputs.
- Reset mid-operation: write addr=9=0x11 committed; next cycle assert rst_n=0 while writing addr=9=0x22 -> after release, addr 9 reads 0.
